pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the instruction-fetch stage of the RISC-V processor.
- Holds the fetch address and advances it by a configurable step each cycle.
- Supports stall, PC-relative branch, absolute jump, trap redirect and a circular return-address stack (RAS).
- Flags misaligned redirect targets and RAS underflow to the control unit.

Parameters:
- WORDSIZE, 64, address/data width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_ADDR, 0, fetch address loaded on reset.
- ALIGN_BITS, 2, number of low address bits that must be zero in any redirect target.
- RAS_DEPTH, 4, RAS entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hold the PC; only trap is honoured while high.
- trap  input  1  redirect to trap_vector.
- trap_vector  input  WORDSIZE  trap target; low ALIGN_BITS forced to zero, never flagged misaligned.
- jump  input  1  absolute redirect to jump_target.
- jump_target  input  WORDSIZE  absolute target.
- branch_taken  input  1  PC-relative redirect.
- branch_offset  input  WORDSIZE  signed two's-complement offset added to addr.
- ras_push  input  1  push addr+STEP onto the RAS.
- ras_pop  input  1  pop the RAS and redirect to the popped value.
- addr  output  WORDSIZE  current fetch address (registered).
- addr_prev  output  WORDSIZE  value addr held in the previous cycle.
- redirect  output  1  high for one cycle after a non-sequential update.
- misaligned  output  1  high for one cycle after a rejected misaligned target.
- ras_underflow  output  1  high for one cycle after a pop on an empty RAS.
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (rst=1 at posedge, overrides everything, including mid-operation):
  - addr=addr_prev=RESET_ADDR.
  - redirect, misaligned and ras_underflow cleared.
  - ras_count=0. Stack contents are don't-care.
- Every non-reset edge: addr_prev<=addr.
- Next-address priority (highest first):
  1. trap: addr<=trap_vector with low ALIGN_BITS cleared; redirect=1. Honoured even when stall=1.
  2. stall=1 (no trap): addr holds. jump, branch, ras_push and ras_pop are ignored. All flags 0.
  3. jump: candidate target is jump_target.
  4. branch_taken: candidate target is addr+branch_offset, modulo 2^WORDSIZE.
  5. ras_pop with ras_count>0: candidate target is the top entry.
  6. Otherwise: addr<=addr+STEP, modulo 2^WORDSIZE. Wrap from all-ones region to low addresses is silent.
- Candidate targets from priorities 3-5:
  - If the low ALIGN_BITS bits are nonzero: addr holds, misaligned=1, redirect=0.
  - Otherwise: addr<=target, redirect=1.
- All flags are single-cycle pulses, registered, and deasserted the cycle after they are raised.
- RAS, evaluated only when stall=0 (trap does not affect the RAS except through these rules):
  - Circular buffer with top pointer.
  - Push writes addr+STEP (current addr before update). If full, it overwrites the oldest entry and ras_count stays at RAS_DEPTH; no error.
  - Pop decrements ras_count and supplies the top entry. The entry is consumed even when a higher-priority redirect (trap/jump/branch) wins the PC.
  - Pop with ras_count=0: no stack change, ras_underflow=1. PC follows the remaining priorities (sequential if no other redirect).
  - Simultaneous push+pop with ras_count>0: the PC candidate is the old top; the top entry is replaced by addr+STEP; ras_count unchanged.
  - Simultaneous push+pop with ras_count=0: ras_underflow=1, then the push proceeds; ras_count=1.
- Latency: a redirect input at edge N appears on addr immediately after edge N. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then 3 idle cycles, defaults -> addr 0x0, 0x4, 0x8, 0xC; addr_prev lags by one; all flags 0.
- At addr=0x100: branch_taken with offset 0xFFFF_FFFF_FFFF_FFF0 (-16) -> addr=0xF0, redirect=1 for one cycle. Same cycle with jump to 0x2000 -> addr=0x2000 (jump wins).
- At addr=0x40: jump_target=0x1002 -> addr stays 0x40, misaligned=1 one cycle. Next idle cycle -> addr=0x44.
- stall=1 for 3 cycles with jump=1 at addr=0x80 -> addr stays 0x80, no flags. Then trap with stall=1, vector 0x8003 -> addr=0x8000, redirect=1.
- RAS, RAS_DEPTH=4:
  - 5 pushes at addr 0x0..0x10 -> ras_count=4, entries 0x8..0x14.
  - 4 pops -> addr sequence 0x14, 0x10, 0xC, 0x8.
  - 5th pop -> ras_underflow=1, sequential step.
- Wrap: addr=0xFFFF_FFFF_FFFF_FFFC idle -> addr=0x0. Reset asserted mid-pop with ras_count=2 -> ras_count=0, addr=RESET_ADDR.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - instruction-fetch program counter with redirect priority and circular return-address stack
module pc_unit #(
    parameter int                    WORDSIZE   = 64,
    parameter int                    STEP       = 4,
    parameter logic [WORDSIZE-1:0]   RESET_ADDR = '0,
    parameter int                    ALIGN_BITS = 2,
    parameter int                    RAS_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          trap,
    input  logic [WORDSIZE-1:0]           trap_vector,
    input  logic                          jump,
    input  logic [WORDSIZE-1:0]           jump_target,
    input  logic                          branch_taken,
    input  logic [WORDSIZE-1:0]           branch_offset,
    input  logic                          ras_push,
    input  logic                          ras_pop,
    output logic [WORDSIZE-1:0]           addr,
    output logic [WORDSIZE-1:0]           addr_prev,
    output logic                          redirect,
    output logic                          misaligned,
    output logic                          ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WORDSIZE-1:0] ONE        = 1;
    localparam logic [WORDSIZE-1:0] ALIGN_MASK = (ONE << ALIGN_BITS) - ONE;

    logic [WORDSIZE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0] addr_prev_q;
    logic                redirect_q, redirect_d;
    logic                misaligned_q, misaligned_d;
    logic                underflow_q, underflow_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       top_q, top_d;
    logic [WORDSIZE-1:0] ras_q [RAS_DEPTH];

    logic                ras_we;
    logic [PW-1:0]       ras_widx;
    logic [WORDSIZE-1:0] seq_addr;
    logic                pop_ok;
    logic                cand_valid;
    logic [WORDSIZE-1:0] cand;

    assign seq_addr = addr_q + WORDSIZE'(STEP);
    assign pop_ok   = ras_pop && (count_q != '0);

    // Next-state for the PC, the flag pulses and the stack pointer/count
    always_comb begin
        addr_d       = addr_q;
        redirect_d   = 1'b0;
        misaligned_d = 1'b0;
        underflow_d  = 1'b0;
        count_d      = count_q;
        top_d        = top_q;
        ras_we       = 1'b0;
        ras_widx     = top_q;
        cand_valid   = 1'b0;
        cand         = seq_addr;

        // The stack advances whenever fetch is not stalled, even if a trap takes the PC
        if (!stall) begin
            if (ras_pop && count_q == '0) begin
                underflow_d = 1'b1;
            end
            if (ras_push && pop_ok) begin
                // Return consumed and a new one pushed: replace top in place
                ras_we   = 1'b1;
                ras_widx = top_q;
            end else if (ras_push) begin
                // When full, top+1 lands on the oldest entry and overwrites it
                ras_we   = 1'b1;
                ras_widx = top_q + PW'(1);
                top_d    = top_q + PW'(1);
                if (count_q != CW'(RAS_DEPTH)) begin
                    count_d = count_q + CW'(1);
                end
            end else if (pop_ok) begin
                top_d   = top_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end

        if (trap) begin
            addr_d     = trap_vector & ~ALIGN_MASK;
            redirect_d = 1'b1;
        end else if (!stall) begin
            if (jump) begin
                cand_valid = 1'b1;
                cand       = jump_target;
            end else if (branch_taken) begin
                cand_valid = 1'b1;
                cand       = addr_q + branch_offset;
            end else if (pop_ok) begin
                cand_valid = 1'b1;
                cand       = ras_q[top_q];
            end

            if (!cand_valid) begin
                addr_d = seq_addr;
            end else if ((cand & ALIGN_MASK) != '0) begin
                misaligned_d = 1'b1;
            end else begin
                addr_d     = cand;
                redirect_d = 1'b1;
            end
        end
    end

    // PC, history, flags and stack bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= RESET_ADDR;
            addr_prev_q  <= RESET_ADDR;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
            count_q      <= '0;
            top_q        <= '0;
        end else begin
            addr_q       <= addr_d;
            addr_prev_q  <= addr_q;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
            count_q      <= count_d;
            top_q        <= top_d;
        end
    end

    // Stack storage; contents are meaningless until counted valid, so no reset
    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_q[ras_widx] <= seq_addr;
        end
    end

    assign addr          = addr_q;
    assign addr_prev     = addr_prev_q;
    assign redirect      = redirect_q;
    assign misaligned    = misaligned_q;
    assign ras_underflow = underflow_q;
    assign ras_count     = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, trap, jump, branch_taken, ras_push, ras_pop;
    logic [63:0] trap_vector, jump_target, branch_offset;
    logic [63:0] addr, addr_prev;
    logic        redirect, misaligned, ras_underflow;
    logic [2:0]  ras_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .WORDSIZE(64), .STEP(4), .RESET_ADDR(64'h0), .ALIGN_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vector(trap_vector),
        .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .ras_push(ras_push), .ras_pop(ras_pop),
        .addr(addr), .addr_prev(addr_prev), .redirect(redirect), .misaligned(misaligned),
        .ras_underflow(ras_underflow), .ras_count(ras_count)
    );

    typedef struct {
        logic        rst, stall, trap, jump, br, push, pop;
        logic [63:0] tv, jt, off;
        logic [63:0] e_addr, e_prev;
        logic        e_red, e_mis, e_unf;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic t, input logic [63:0] tv,
                                input logic j, input logic [63:0] jt, input logic b, input logic [63:0] off,
                                input logic pu, input logic po, input logic [63:0] ea, input logic [63:0] ep,
                                input logic er, input logic em, input logic eu, input int ec);
        vec_t v;
        v.rst = r; v.stall = s; v.trap = t; v.tv = tv; v.jump = j; v.jt = jt; v.br = b; v.off = off;
        v.push = pu; v.pop = po; v.e_addr = ea; v.e_prev = ep; v.e_red = er; v.e_mis = em;
        v.e_unf = eu; v.e_cnt = ec;
        return v;
    endfunction

    task automatic drive(input logic r, input logic s, input logic t, input logic [63:0] tv,
                         input logic j, input logic [63:0] jt, input logic b, input logic [63:0] off,
                         input logic pu, input logic po);
        rst = r; stall = s; trap = t; trap_vector = tv; jump = j; jump_target = jt;
        branch_taken = b; branch_offset = off; ras_push = pu; ras_pop = po;
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ea, input logic [63:0] ep,
                             input logic er, input logic em, input logic eu, input int ec);
        chk64({tag, " addr"}, addr, ea);
        chk64({tag, " addr_prev"}, addr_prev, ep);
        chk64({tag, " redirect"}, {63'd0, redirect}, {63'd0, er});
        chk64({tag, " misaligned"}, {63'd0, misaligned}, {63'd0, em});
        chk64({tag, " ras_underflow"}, {63'd0, ras_underflow}, {63'd0, eu});
        chk64({tag, " ras_count"}, {61'd0, ras_count}, 64'(ec));
    endtask

    // one cycle: inputs applied at negedge, outputs sampled at the following negedge
    task automatic step(input logic r, input logic s, input logic t, input logic [63:0] tv,
                        input logic j, input logic [63:0] jt, input logic b, input logic [63:0] off,
                        input logic pu, input logic po);
        drive(r, s, t, tv, j, jt, b, off, pu, po);
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [63:0] M16 = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        //                 rst st tr tv        jp jt        br off  pu po   addr     prev     rd mi uf cnt
        vecs.push_back(mk(1, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h0,   64'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h4,   64'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h8,   64'h4,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'hC,   64'h8,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h100,  0, 0,   0, 0,   64'h100, 64'hC,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        1, M16, 0, 0,   64'hF0,  64'h100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'hF4,  64'hF0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h100,  0, 0,   0, 0,   64'h100, 64'hF4,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h2000, 1, M16, 0, 0,   64'h2000,64'h100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h40,   0, 0,   0, 0,   64'h40,  64'h2000,1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h1002, 0, 0,   0, 0,   64'h40,  64'h40,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h44,  64'h40,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h80,   0, 0,   0, 0,   64'h80,  64'h44,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,         1, 64'h1000, 0, 0,   0, 0,   64'h80,  64'h80,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,         1, 64'h1000, 0, 0,   0, 0,   64'h80,  64'h80,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,         1, 64'h1000, 0, 0,   0, 0,   64'h80,  64'h80,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 64'h8003,  0, 0,        0, 0,   0, 0,   64'h8000,64'h80,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h8004,64'h8000,0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        1, 64'h2,0, 0,  64'h8004,64'h8004,0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h0,    0, 0,   0, 0,   64'h0,   64'h8004,1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h4,   64'h0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h8,   64'h4,   0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'hC,   64'h8,   0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h10,  64'hC,   0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h14,  64'h10,  0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h14,  64'h14,  1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h10,  64'h14,  1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'hC,   64'h10,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h8,   64'hC,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'hC,   64'h8,   0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 1,   64'h10,  64'hC,   0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 1,   64'h10,  64'h10,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h14,  64'h10,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h18,  64'h14,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h1C,  64'h18,  0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,         1, 64'h200,  0, 0,   0, 1,   64'h200, 64'h1C,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h18,  64'h200, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h1C,  64'h18,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,         0, 0,        0, 0,   0, 1,   64'h1C,  64'h1C,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h300,   0, 0,        0, 0,   0, 1,   64'h300, 64'h1C,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         1, TOP,      0, 0,   0, 0,   TOP,     64'h300, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h0,   TOP,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h4,   64'h0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   1, 0,   64'h8,   64'h4,   0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h0,   64'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 0,   64'h4,   64'h0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,         0, 0,        0, 0,   0, 1,   64'h8,   64'h4,   0, 0, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].trap, vecs[i].tv, vecs[i].jump, vecs[i].jt,
                 vecs[i].br, vecs[i].off, vecs[i].push, vecs[i].pop);
            check_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_prev, vecs[i].e_red,
                      vecs[i].e_mis, vecs[i].e_unf, vecs[i].e_cnt);
        end

        // six pushes from 0x1000: only the newest four returns survive, popped newest first
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 64'h1000, 0, 0, 0, 0);
        check_all("seq jump", 64'h1000, 64'h0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            check_all($sformatf("seq push%0d", k), 64'h1004 + 64'(4 * k), 64'h1000 + 64'(4 * k),
                      0, 0, 0, (k < 3) ? k + 1 : 4);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            check_all($sformatf("seq pop%0d", k), 64'h1018 - 64'(4 * k),
                      (k == 0) ? 64'h1018 : 64'h1018 - 64'(4 * (k - 1)), 1, 0, 0, 3 - k);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_all("seq underflow", 64'h1010, 64'h100C, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all("seq flag drop", 64'h1014, 64'h1010, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
